// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Purpose : bundles the transmit request, oversampling tick, payload and the
//           serial-side status of uart_tx_param into one port.
// Signals : tx_start     request a frame (level, sampled every clk)
//           s_tick       one-clk oversampling tick from the baud generator
//           din          word to send, captured when the frame is accepted
//           parity_mode  00 none, 01 even, 10 odd, 11 none
//           tx           serial line (idles high)
//           tx_done_tick one-clk pulse at the end of a frame
//           busy         high from acceptance through the tx_done_tick cycle
//           state_dbg    current transmitter state, for observation only
// Modports: master drives the request side (FIFO / baud generator / bench),
//           slave is the transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic            s_tick;
  logic [DBIT-1:0] din;
  logic [1:0]      parity_mode;
  logic            tx;
  logic            tx_done_tick;
  logic            busy;
  logic [2:0]      state_dbg;

  modport master (
    output tx_start, s_tick, din, parity_mode,
    input  tx, tx_done_tick, busy, state_dbg
  );

  modport slave (
    input  tx_start, s_tick, din, parity_mode,
    output tx, tx_done_tick, busy, state_dbg
  );
endinterface

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Purpose : parametrised UART transmitter. Sends start bit, DBIT data bits
//           (LSB first), an optional even/odd parity bit and a stop period of
//           SB_TICK oversampling ticks. Bit timing follows bus.s_tick.
// Ports   : clk    system clock, rising edge
//           reset  synchronous, active-low
//           bus    uart_tx_param_if.slave (request, payload, tx, status)
//
// Handshake: tx_start acts as a request and busy as the inverse of ready. A
// request is accepted on a clk edge where the transmitter is IDLE and is not
// emitting tx_done_tick; din and parity_mode are captured on that same edge.
// Requests made while busy are dropped, never queued.
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_param_if.slave bus
);

  localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  logic [SW-1:0]   r_s, w_s_next;
  logic [NW-1:0]   r_n, w_n_next;
  logic [DBIT-1:0] r_b, w_b_next;
  logic            r_p, w_p_next;
  logic            r_par_en, w_par_en_next;
  logic            r_done, w_done_next;
  logic            r_tx, w_tx_next;
  logic            r_busy, w_busy_next;

  logic            w_accept;
  logic            w_par_on;
  logic            w_par_bit;

  // The cycle that carries tx_done_tick is already IDLE; a request seen
  // there belongs to the frame that just ended and is dropped.
  assign w_accept  = bus.tx_start && !r_done;
  assign w_par_on  = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
  // Even parity is the XOR of the data bits; odd parity inverts it.
  assign w_par_bit = (^bus.din) ^ (bus.parity_mode == 2'b10);

  // State and datapath register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_b      <= '0;
      r_p      <= 1'b0;
      r_par_en <= 1'b0;
      r_done   <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_s      <= w_s_next;
      r_n      <= w_n_next;
      r_b      <= w_b_next;
      r_p      <= w_p_next;
      r_par_en <= w_par_en_next;
      r_done   <= w_done_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_next  = r_state;
    w_s_next      = r_s;
    w_n_next      = r_n;
    w_b_next      = r_b;
    w_p_next      = r_p;
    w_par_en_next = r_par_en;
    w_done_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Acceptance is not tick-aligned, so the start bit may run up to one
        // tick period long.
        if (w_accept) begin
          w_b_next      = bus.din;
          w_p_next      = w_par_on ? w_par_bit : 1'b0;
          w_par_en_next = w_par_on;
          w_s_next      = '0;
          w_state_next  = S_START;
        end
      end
      S_START: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = S_DATA;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next = '0;
            w_b_next = r_b >> 1;
            if (r_n == N_LAST) begin
              w_state_next = r_par_en ? S_PARITY : S_STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s_next     = '0;
            w_state_next = S_STOP;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bus.s_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_s_next     = '0;
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output decode; tx and busy are registered one clk behind the state.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   w_tx_next = 1'b1;
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_b[0];
      S_PARITY: w_tx_next = r_p;
      S_STOP:   w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign bus.tx           = r_tx;
  assign bus.tx_done_tick = r_done;
  assign bus.busy         = r_busy;
  assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Purpose : directed bench for uart_tx_param. Instance a uses the default
//           8-bit / 1-stop configuration, instance b uses DBIT=7, SB_TICK=32.
//           Both share clk, reset and s_tick. The tick period is kept short
//           so a full set of frames stays within a small cycle count.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int TP = 8;   // clk cycles per s_tick
  localparam int OS = 16;

  logic clk;
  logic reset;

  uart_tx_param_if #(.DBIT(8)) ifa ();
  uart_tx_param_if #(.DBIT(7)) ifb ();

  uart_tx_param #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  uart_tx_param #(.DBIT(7), .OVERSAMPLE(16), .SB_TICK(32)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  // Observation state
  int   sel = 0;
  int   phase = 0;
  logic tick_prev;
  logic obs_tx, obs_busy, obs_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk: sample outputs at the falling edge, then drive the next tick.
  task automatic step();
    @(negedge clk);
    obs_tx    = (sel != 0) ? ifb.tx : ifa.tx;
    obs_busy  = (sel != 0) ? ifb.busy : ifa.busy;
    obs_done  = (sel != 0) ? ifb.tx_done_tick : ifa.tx_done_tick;
    tick_prev = ifa.s_tick;
    ifa.s_tick = (phase == 0);
    ifb.s_tick = (phase == 0);
    phase = (phase + 1) % TP;
  endtask

  task automatic drive_start(input logic v);
    if (sel != 0) ifb.tx_start = v;
    else          ifa.tx_start = v;
  endtask

  task automatic set_din(input logic [8:0] d, input logic [1:0] mode);
    if (sel != 0) begin
      ifb.din = d[6:0];
      ifb.parity_mode = mode;
    end else begin
      ifa.din = d[7:0];
      ifa.parity_mode = mode;
    end
  endtask

  // Expected line levels in transmission order, one character per bit.
  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back((s[i] == "1") ? 1'b1 : 1'b0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (obs_tx !== 1'b1 || obs_done !== 1'b0 || obs_busy !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  // mid_kind: 0 none, 1 din->FF in DATA, 2 second tx_start in DATA,
  //           3 one-clk reset during data bit 3
  task automatic run_frame(input string tag, input int exp_ticks, input int mid_kind);
    int   tcnt;
    int   steps;
    int   busy_low;
    int   next_mid;
    logic got_done;
    tcnt = 0; steps = 0; busy_low = 0; next_mid = OS / 2; got_done = 1'b0;
    // Launch just after a tick so no tick lands in the acceptance window.
    while (phase != 2) step();
    drive_start(1'b1);
    step();
    drive_start(1'b0);
    check({tag, " tx before fall"}, obs_tx, 1'b1);
    check({tag, " busy before fall"}, obs_busy, 1'b0);
    step();
    check({tag, " tx fall"}, obs_tx, 1'b0);
    check({tag, " busy rise"}, obs_busy, 1'b1);
    while (!got_done && steps < exp_ticks * TP + 50) begin
      step();
      steps++;
      if (tick_prev) tcnt++;
      if (!obs_busy) busy_low++;
      if (obs_done) got_done = 1'b1;
      if (tick_prev && tcnt == next_mid && exp_q.size() > 0) begin
        check({tag, " bit"}, obs_tx, exp_q.pop_front());
        next_mid += OS;
      end
      if (tick_prev && mid_kind == 1 && tcnt == 3 * OS) set_din(9'h0FF, (sel != 0) ? ifb.parity_mode : ifa.parity_mode);
      if (tick_prev && mid_kind == 2 && tcnt == 3 * OS) begin
        set_din(9'h055, 2'b00);
        drive_start(1'b1);
      end
      if (tick_prev && mid_kind == 2 && tcnt == 4 * OS) drive_start(1'b0);
      if (tick_prev && mid_kind == 3 && tcnt == 4 * OS + OS / 2) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        check({tag, " tx after reset"}, obs_tx, 1'b1);
        check({tag, " busy after reset"}, obs_busy, 1'b0);
        exp_q.delete();
        return;
      end
    end
    check({tag, " done seen"}, got_done, 1'b1);
    check({tag, " frame ticks"}, tcnt, exp_ticks);
    check({tag, " busy held"}, busy_low, 0);
    check({tag, " bits left"}, exp_q.size(), 0);
    check({tag, " busy in done cycle"}, obs_busy, 1'b1);
    step();
    check({tag, " done one clk"}, obs_done, 1'b0);
    check({tag, " busy fall"}, obs_busy, 1'b0);
    check({tag, " tx idle"}, obs_tx, 1'b1);
  endtask

  initial begin
    int bad;
    reset = 1'b0;
    ifa.tx_start = 1'b1; ifa.s_tick = 1'b0; ifa.din = 8'h00; ifa.parity_mode = 2'b00;
    ifb.tx_start = 1'b0; ifb.s_tick = 1'b0; ifb.din = 7'h00; ifb.parity_mode = 2'b00;

    // Reset held with a pending request
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) bad++;
    end
    check("reset hold", bad, 0);
    check("reset tx", obs_tx, 1'b1);
    check("reset busy", obs_busy, 1'b0);
    check("reset done", obs_done, 1'b0);
    ifa.tx_start = 1'b0;
    reset = 1'b1;
    idle_check("post reset idle", 20);

    // 8N1, din 2A
    sel = 0;
    set_din(9'h02A, 2'b00);
    push_bits("0010101001");
    run_frame("8n1", 160, 0);

    // Even parity, din changed to FF mid-DATA
    set_din(9'h02A, 2'b01);
    push_bits("00101010011");
    run_frame("even", 176, 1);

    // Odd parity
    set_din(9'h02A, 2'b10);
    push_bits("00101010001");
    run_frame("odd", 176, 0);

    // Second request during DATA is dropped
    set_din(9'h02A, 2'b00);
    push_bits("0010101001");
    run_frame("busy_rej", 160, 2);
    idle_check("busy_rej no second frame", 100);

    // Reset during data bit 3, then a fresh frame
    set_din(9'h02A, 2'b00);
    push_bits("0010101001");
    run_frame("mid_rst", 160, 3);
    idle_check("mid_rst no done", 300);
    push_bits("0010101001");
    run_frame("fresh", 160, 0);

    // DBIT=7, SB_TICK=32, din 55, even parity
    sel = 1;
    set_din(9'h055, 2'b01);
    push_bits("0101010101");
    run_frame("gen7", 176, 0);
    idle_check("gen7 idle", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the successor to the fixed 8N1 `Tx`. It serialises a parallel word onto `tx` as start bit, DBIT data bits (LSB first), an optional parity bit and a configurable stop period. Bit timing is paced by an external oversampling tick `s_tick` from the baud-rate generator. It sits between the baud generator/transmit FIFO and the pad, and adds runtime parity, a `busy` flag and input latching.

## Interface
- `DBIT`, 8: data bits per frame; legal 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; legal 8..32.
- `SB_TICK`, 16: `s_tick` pulses for the stop period (16 = 1 stop, 24 = 1.5, 32 = 2 at OVERSAMPLE=16); must be ≥ OVERSAMPLE/2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `tx_start` in 1: request a frame; level-sampled each `clk`.
- `s_tick` in 1: one-`clk`-wide oversampling tick.
- `din` in DBIT: word to send; sampled when the frame is accepted.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none (reserved); sampled when the frame is accepted.
- `tx` out 1: serial line; idles high.
- `tx_done_tick` out 1: one-`clk` pulse at end of frame.
- `busy` out 1: high from acceptance until the `tx_done_tick` cycle inclusive.

## Operation
- Registers:
  - state: IDLE, START, DATA, PARITY, STOP.
  - tick counter `s`: wide enough for max(OVERSAMPLE, SB_TICK)−1.
  - bit counter `n`: wide enough for DBIT−1.
  - shift register `b` (DBIT bits) and latched parity bit `p`.
- All registers are updated on `clk`. `tx` is a registered output.
- IDLE: `tx`=1. On `tx_start`=1, accept the frame:
  - latch `din`→`b`, compute `p` from `din` and `parity_mode`, latch the mode;
  - `s`←0; go to START.
  - Acceptance does not wait for `s_tick`.
- START: `tx`=0. On each `s_tick`, `s`++. On the `s_tick` where `s`=OVERSAMPLE−1: `s`←0, `n`←0, go to DATA.
- DATA: `tx`=`b[0]`. On the `s_tick` where `s`=OVERSAMPLE−1:
  - `s`←0, `b`←`b`>>1;
  - if `n`=DBIT−1, go to PARITY when the mode is 01/10, otherwise go to STOP;
  - else `n`++.
- PARITY: `tx`=`p`. After OVERSAMPLE ticks go to STOP.
  - even: `p` = XOR of the data bits;
  - odd: `p` = inverted XOR of the data bits.
- STOP: `tx`=1. On the `s_tick` where `s`=SB_TICK−1: pulse `tx_done_tick`, go to IDLE.
- `tx_start` outside IDLE is ignored (not queued).
- Changes to `din` and `parity_mode` after acceptance have no effect on the current frame.
- Reset (`reset`=0 at a `clk` edge): state IDLE, `s`=0, `n`=0, `b`=0, `p`=0, `tx`=1, `tx_done_tick`=0, `busy`=0. Reset overrides every other input, including mid-frame; an aborted frame produces no `tx_done_tick`.

## Timing
- Acceptance latency: `tx` falls on the first `clk` edge after the edge that sampled `tx_start`=1 in IDLE. `busy` rises on that same edge.
- Every bit lasts exactly OVERSAMPLE `s_tick` pulses, measured from the first tick after entering the state. The start bit may therefore run up to one tick period longer, because acceptance is not tick-aligned.
- Frame length in ticks: OVERSAMPLE×(1+DBIT+P) + SB_TICK, where P=1 when parity is enabled.
- `tx_done_tick` is high for exactly one `clk`, one edge after the final stop `s_tick` is sampled. `busy` falls on the next edge.
- Back-to-back frames: with `tx_start` held high, the next frame is accepted on the edge after IDLE is re-entered. The minimum idle gap is 1 `clk`.
- A `tx_start` that coincides with `tx_done_tick` is ignored.
- An `s_tick` in IDLE has no effect.

## Test plan
- Reset: hold `reset`=0 for 5 clk with `tx_start`=1 → `tx`=1, `busy`=0, `tx_done_tick`=0 throughout; no frame starts until `reset`=1.
- Default 8N1: `din`=8'h2A, `parity_mode`=00, `s_tick` every 325 clk, one-clk `tx_start` pulse → `tx` = 0,0,1,0,1,0,1,0,0,1, each bit 16 ticks; exactly one `tx_done_tick` one clk after the 160th tick; `busy` high across the frame.
- Parity: `din`=8'h2A with `parity_mode`=01 → parity bit 1; with 10 → parity bit 0; frame is 176 ticks. Change `din` to 8'hFF mid-DATA → transmitted bits unchanged.
- Busy rejection: assert `tx_start` again during DATA with `din`=8'h55 → no second frame, a single `tx_done_tick`, `tx` returns to 1 and stays there.
- Mid-frame reset: `reset`=0 for 1 clk during data bit 3 → `tx`=1 and `busy`=0 after that edge; no `tx_done_tick`; next `tx_start` sends a complete fresh frame.
- Generics: DBIT=7, SB_TICK=32, `din`=7'h55, even parity → `tx` = 0,1,0,1,0,1,0,1,0, then stop held high for 32 ticks; `tx_done_tick` after 16+112+16+32=176 ticks.
